tft_uart_cmd_ctrl: RTL and testbench

Command sequencer between the UART receiver and the TFT/SDRAM datapath. It parses the ASCII command stream ("TFT_C", "TFT_C:i,hhhh", "TFT_L:hhhhh") arriving as received bytes, and issues decoded commands to the TFT/SDRAM controller over a valid/ready handshake. After a load command it converts the following hex-pair payload into a byte stream for the frame-buffer writer.

---
 rtl/tft_cmd_pkg.sv | 51 +++++
 rtl/hex_ascii_decode.sv | 27 ++
 rtl/tft_uart_cmd_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_tft_uart_cmd_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tft_cmd_pkg
// Brief    : Opcodes, parser states and ASCII constants for the TFT UART
//            command sequencer.
// Revision : 1.0
// ============================================================================
package tft_cmd_pkg;

    localparam logic [1:0] OP_CLEAR    = 2'd0;
    localparam logic [1:0] OP_SETCOLOR = 2'd1;
    localparam logic [1:0] OP_LOAD     = 2'd2;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_PFX    = 4'd1;
    localparam logic [3:0] S_OP     = 4'd2;
    localparam logic [3:0] S_CSEP   = 4'd3;
    localparam logic [3:0] S_LSEP   = 4'd4;
    localparam logic [3:0] S_IDX    = 4'd5;
    localparam logic [3:0] S_COMMA  = 4'd6;
    localparam logic [3:0] S_HEXV   = 4'd7;
    localparam logic [3:0] S_LF     = 4'd8;
    localparam logic [3:0] S_ISSUE  = 4'd9;
    localparam logic [3:0] S_STREAM = 4'd10;
    localparam logic [3:0] S_FLUSH  = 4'd11;

    localparam logic [7:0] C_ASCII_T     = 8'h54;
    localparam logic [7:0] C_ASCII_F     = 8'h46;
    localparam logic [7:0] C_ASCII_USCR  = 8'h5F;
    localparam logic [7:0] C_ASCII_C     = 8'h43;
    localparam logic [7:0] C_ASCII_L     = 8'h4C;
    localparam logic [7:0] C_ASCII_COLON = 8'h3A;
    localparam logic [7:0] C_ASCII_COMMA = 8'h2C;
    localparam logic [7:0] C_ASCII_CR    = 8'h0D;
    localparam logic [7:0] C_ASCII_LF    = 8'h0A;

    localparam logic [2:0] C_DIGITS_SETCOLOR = 3'd4;
    localparam logic [2:0] C_DIGITS_LOAD     = 3'd5;

    // Character expected at position pos (1..3) of "TFT_"; 'T' at 0 opens the match.
    function automatic logic [7:0] prefix_char(input logic [1:0] pos);
        case (pos)
            2'd1:    prefix_char = C_ASCII_F;
            2'd2:    prefix_char = C_ASCII_T;
            2'd3:    prefix_char = C_ASCII_USCR;
            default: prefix_char = C_ASCII_T;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_ascii_decode.sv
`default_nettype none
// ============================================================================
// Module   : hex_ascii_decode
// Brief    : Combinational ASCII character to hex nibble decoder.
// Revision : 1.0
// ============================================================================
module hex_ascii_decode (
    input  logic [7:0] chr_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        is_hex_o = 1'b0;
        nibble_o = 4'h0;
        if (chr_i >= 8'h30 && chr_i <= 8'h39) begin
            is_hex_o = 1'b1;
            nibble_o = chr_i[3:0];
        end else if ((chr_i >= 8'h41 && chr_i <= 8'h46) ||
                     (chr_i >= 8'h61 && chr_i <= 8'h66)) begin
            is_hex_o = 1'b1;
            nibble_o = chr_i[3:0] + 4'd9;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tft_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tft_uart_cmd_ctrl
// Brief    : Parses "TFT_C", "TFT_C:i,hhhh" and "TFT_L:hhhhh" UART commands,
//            issues them on a valid/ready port and unpacks LOAD hex payloads.
// Revision : 1.0
// ============================================================================
module tft_uart_cmd_ctrl #(
    parameter int TIMEOUT_CYC = 250000,
    parameter int CNT_W       = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_op,
    output logic [3:0]       cmd_idx,
    output logic [CNT_W-1:0] cmd_data,
    output logic [7:0]       px_data,
    output logic             px_valid,
    output logic             stream_done,
    output logic             err
);
    import tft_cmd_pkg::*;

    localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W:0]   REM_ONE  = (CNT_W+1)'(1);

    logic [3:0]       state_q, state_d;
    logic [1:0]       pfx_cnt_q, pfx_cnt_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [2:0]       dig_q, dig_d;
    logic [3:0]       hi_q, hi_d;
    logic             half_q, half_d;
    logic [CNT_W:0]   rem_q, rem_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       px_data_q, px_data_d;
    logic             px_valid_q, px_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             w_is_hex;
    logic [3:0]       w_nibble;
    logic             w_syntax_err;
    logic [2:0]       w_digits;

    hex_ascii_decode u_hex (
        .chr_i    (rx_data),
        .is_hex_o (w_is_hex),
        .nibble_o (w_nibble)
    );

    assign w_digits = (op_q == OP_LOAD) ? C_DIGITS_LOAD : C_DIGITS_SETCOLOR;

    always_comb begin
        state_d      = state_q;
        pfx_cnt_d    = pfx_cnt_q;
        op_d         = op_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        dig_d        = dig_q;
        hi_d         = hi_q;
        half_d       = half_q;
        rem_d        = rem_q;
        tmo_d        = tmo_q;
        px_data_d    = px_data_q;
        px_valid_d   = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        w_syntax_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Stray bytes before any prefix match are not treated as errors.
                if (rx_valid && rx_data == C_ASCII_T) begin
                    state_d   = S_PFX;
                    pfx_cnt_d = 2'd1;
                    op_d      = OP_CLEAR;
                    idx_d     = 4'h0;
                    acc_d     = '0;
                end
            end
            S_PFX: if (rx_valid) begin
                if (rx_data == prefix_char(pfx_cnt_q)) begin
                    if (pfx_cnt_q == 2'd3) state_d = S_OP;
                    else                   pfx_cnt_d = pfx_cnt_q + 2'd1;
                end else w_syntax_err = 1'b1;
            end
            S_OP: if (rx_valid) begin
                if (rx_data == C_ASCII_C) state_d = S_CSEP;
                else if (rx_data == C_ASCII_L) begin
                    state_d = S_LSEP;
                    op_d    = OP_LOAD;
                end else w_syntax_err = 1'b1;
            end
            S_CSEP: if (rx_valid) begin
                if (rx_data == C_ASCII_CR) state_d = S_LF;
                else if (rx_data == C_ASCII_COLON) begin
                    state_d = S_IDX;
                    op_d    = OP_SETCOLOR;
                end else w_syntax_err = 1'b1;
            end
            S_LSEP: if (rx_valid) begin
                if (rx_data == C_ASCII_COLON) begin
                    state_d = S_HEXV;
                    acc_d   = '0;
                    dig_d   = 3'd0;
                end else w_syntax_err = 1'b1;
            end
            S_IDX: if (rx_valid) begin
                if (w_is_hex) begin
                    idx_d   = w_nibble;
                    state_d = S_COMMA;
                end else w_syntax_err = 1'b1;
            end
            S_COMMA: if (rx_valid) begin
                if (rx_data == C_ASCII_COMMA) begin
                    state_d = S_HEXV;
                    acc_d   = '0;
                    dig_d   = 3'd0;
                end else w_syntax_err = 1'b1;
            end
            S_HEXV: if (rx_valid) begin
                if (w_is_hex && dig_q != w_digits) begin
                    acc_d = {acc_q[CNT_W-5:0], w_nibble};
                    dig_d = dig_q + 3'd1;
                end else if (rx_data == C_ASCII_CR && dig_q == w_digits)
                    state_d = S_LF;
                else w_syntax_err = 1'b1;
            end
            S_LF: if (rx_valid) begin
                if (rx_data == C_ASCII_LF) state_d = S_ISSUE;
                else                       w_syntax_err = 1'b1;
            end
            S_ISSUE: begin
                // Bytes arriving while the command is pending are overruns.
                err_d = rx_valid;
                if (cmd_ready) begin
                    state_d = (op_q == OP_LOAD) ? S_STREAM : S_IDLE;
                    rem_d   = {1'b0, acc_q} + REM_ONE;
                    half_d  = 1'b0;
                    tmo_d   = '0;
                end
            end
            S_STREAM: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    if (rx_data == C_ASCII_CR || rx_data == C_ASCII_LF) begin
                        state_d = S_STREAM;
                    end else if (w_is_hex) begin
                        if (!half_q) begin
                            hi_d   = w_nibble;
                            half_d = 1'b1;
                        end else begin
                            half_d     = 1'b0;
                            px_data_d  = {hi_q, w_nibble};
                            px_valid_d = 1'b1;
                            rem_d      = rem_q - REM_ONE;
                            if (rem_q == REM_ONE) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_FLUSH: if (rx_valid && rx_data == C_ASCII_LF) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // An offending LF already terminates the line, so no flush is needed.
        if (w_syntax_err) begin
            err_d   = 1'b1;
            state_d = (rx_data == C_ASCII_LF) ? S_IDLE : S_FLUSH;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            pfx_cnt_q  <= 2'd0;
            op_q       <= OP_CLEAR;
            idx_q      <= 4'h0;
            acc_q      <= '0;
            dig_q      <= 3'd0;
            hi_q       <= 4'h0;
            half_q     <= 1'b0;
            rem_q      <= '0;
            tmo_q      <= '0;
            px_data_q  <= 8'h00;
            px_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pfx_cnt_q  <= pfx_cnt_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            dig_q      <= dig_d;
            hi_q       <= hi_d;
            half_q     <= half_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            px_data_q  <= px_data_d;
            px_valid_q <= px_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_valid   = (state_q == S_ISSUE);
    assign cmd_op      = op_q;
    assign cmd_idx     = idx_q;
    assign cmd_data    = acc_q;
    assign px_data     = px_data_q;
    assign px_valid    = px_valid_q;
    assign stream_done = done_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tft_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_uart_cmd_ctrl
// Brief    : Randomized self-checking bench for the TFT UART command sequencer.
// Revision : 1.0
// ============================================================================
module tb_tft_uart_cmd_ctrl;

    localparam int TMO = 1000;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_idx;
    logic [19:0] cmd_data;
    logic [7:0]  px_data;
    logic        px_valid;
    logic        stream_done;
    logic        err;

    int errors = 0;
    int checks = 0;

    tft_uart_cmd_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(20)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_idx     (cmd_idx),
        .cmd_data    (cmd_data),
        .px_data     (px_data),
        .px_valid    (px_valid),
        .stream_done (stream_done),
        .err         (err)
    );

    always #5 sys_clk = ~sys_clk;

    // Event capture: only the monitor writes these; tests work on deltas.
    logic [25:0] cmd_cap[$];
    logic [7:0]  px_cap[$];
    int err_cnt = 0, done_cnt = 0, done_bad = 0;
    int b_cmd, b_px, b_err, b_done;

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (cmd_valid && cmd_ready) cmd_cap.push_back({cmd_op, cmd_idx, cmd_data});
            if (px_valid) px_cap.push_back(px_data);
            if (err) err_cnt++;
            if (stream_done) begin
                done_cnt++;
                if (!px_valid) done_bad++;
            end
        end
    end

    task automatic mark();
        b_cmd = cmd_cap.size(); b_px = px_cap.size();
        b_err = err_cnt;        b_done = done_cnt;
    endtask

    task automatic tick();
        @(posedge sys_clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], $urandom_range(0, 2));
    endtask

    task automatic send_crlf();
        send_byte(8'h0D, 0);
        send_byte(8'h0A, 0);
        repeat (3) tick();
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    endfunction

    task automatic send_pair(input logic [7:0] v, input int gap);
        send_byte(hexc(v[7:4], 1'($urandom_range(0, 1))), $urandom_range(0, 3));
        send_byte(hexc(v[3:0], 1'($urandom_range(0, 1))), gap);
    endtask

    task automatic send_load_hdr(input logic [19:0] cnt);
        send_str("TFT_L:");
        for (int d = 4; d >= 0; d--) send_byte(hexc(cnt[d*4 +: 4], 1'($urandom_range(0, 1))), 0);
        send_crlf();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({cmd_valid, cmd_op, cmd_idx, cmd_data, px_data, px_valid, stream_done, err} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {cmd_valid, cmd_op, cmd_idx, cmd_data, px_data, px_valid, stream_done, err});
        end
        sys_rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cmd_valid, err, px_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: got %b want 000", {cmd_valid, err, px_valid});
        end
    endtask

    task automatic test_clear();
        cmd_ready = 1'b1;
        mark();
        send_str("TFT_C");
        send_crlf();
        checks++;
        if (cmd_cap.size() - b_cmd !== 1) begin
            errors++; $display("FAIL clear_count: got %0d want 1", cmd_cap.size() - b_cmd);
        end else begin
            checks++;
            if (cmd_cap[b_cmd] !== 26'd0) begin
                errors++; $display("FAIL clear_value: got %h want 0", cmd_cap[b_cmd]);
            end
        end
        checks++;
        if (err_cnt - b_err !== 0) begin
            errors++; $display("FAIL clear_err: got %0d want 0", err_cnt - b_err);
        end
    endtask

    task automatic test_setcolor();
        logic [3:0]  idx;
        logic [15:0] rgb;
        logic [25:0] exp;
        int bad;
        for (int it = 0; it < 5; it++) begin
            if (it == 0)      begin idx = 4'hA; rgb = 16'h2C1F; end
            else if (it == 1) begin idx = 4'h4; rgb = 16'hDE72; end
            else begin idx = 4'($urandom); rgb = 16'($urandom); end
            exp = {2'd1, idx, 4'h0, rgb};
            cmd_ready = 1'b0;
            mark();
            send_str("TFT_C:");
            send_byte(hexc(idx, 1'($urandom_range(0, 1))), 0);
            send_byte(8'h2C, 0);
            for (int d = 3; d >= 0; d--) send_byte(hexc(rgb[d*4 +: 4], 1'($urandom_range(0, 1))), 0);
            send_crlf();
            for (int k = 0; k < 20 && !cmd_valid; k++) tick();
            checks++;
            if (cmd_valid !== 1'b1) begin
                errors++; $display("FAIL setcolor_valid[%0d]: got %b want 1", it, cmd_valid);
            end
            bad = 0;
            for (int k = 0; k < 10; k++) begin
                if ({cmd_valid, cmd_op, cmd_idx, cmd_data} !== {1'b1, exp}) bad++;
                tick();
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL setcolor_hold[%0d]: got %0d unstable cycles want 0", it, bad);
            end
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            tick();
            checks++;
            if (cmd_cap.size() - b_cmd !== 1) begin
                errors++; $display("FAIL setcolor_count[%0d]: got %0d want 1", it, cmd_cap.size() - b_cmd);
            end else begin
                checks++;
                if (cmd_cap[b_cmd] !== exp) begin
                    errors++; $display("FAIL setcolor_value[%0d]: got %h want %h", it, cmd_cap[b_cmd], exp);
                end
            end
            checks++;
            if ({cmd_valid, 32'(err_cnt - b_err)} !== 33'd0) begin
                errors++; $display("FAIL setcolor_after[%0d]: valid=%b errs=%0d want 0/0", it, cmd_valid, err_cnt - b_err);
            end
        end
    endtask

    task automatic test_load(input int n, input bit fixed);
        logic [7:0] exp_q[$];
        logic [7:0] v;
        int bad;
        cmd_ready = 1'b1;
        mark();
        for (int i = 0; i < n; i++) begin
            v = fixed ? 8'((i * 2) * 16 + i * 2 + 1) : 8'($urandom);
            exp_q.push_back(v);
        end
        send_load_hdr(20'(n - 1));
        for (int i = 0; i < n; i++) begin
            if (!fixed && $urandom_range(0, 3) == 0) send_byte($urandom_range(0, 1) ? 8'h0D : 8'h0A, 0);
            send_pair(exp_q[i], $urandom_range(0, 3));
        end
        repeat (3) tick();
        checks++;
        if (cmd_cap.size() - b_cmd !== 1 || cmd_cap[b_cmd] !== {2'd2, 4'h0, 20'(n - 1)}) begin
            errors++;
            $display("FAIL load_cmd[n=%0d]: got %0d cmds first=%h want 1 cmd %h", n,
                     cmd_cap.size() - b_cmd, (cmd_cap.size() > b_cmd) ? cmd_cap[b_cmd] : 26'd0,
                     {2'd2, 4'h0, 20'(n - 1)});
        end
        checks++;
        if (px_cap.size() - b_px !== n) begin
            errors++; $display("FAIL load_bytes_count[n=%0d]: got %0d want %0d", n, px_cap.size() - b_px, n);
        end else begin
            bad = 0;
            for (int i = 0; i < n; i++) if (px_cap[b_px + i] !== exp_q[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL load_bytes[n=%0d]: got %0d wrong bytes want 0", n, bad);
            end
        end
        checks++;
        if (done_cnt - b_done !== 1 || done_bad !== 0) begin
            errors++; $display("FAIL load_done[n=%0d]: got %0d pulses misaligned=%0d want 1/0", n, done_cnt - b_done, done_bad);
        end
        checks++;
        if (err_cnt - b_err !== 0) begin
            errors++; $display("FAIL load_err[n=%0d]: got %0d want 0", n, err_cnt - b_err);
        end
        mark();
        send_str("TFT_C");
        send_crlf();
        checks++;
        if (cmd_cap.size() - b_cmd !== 1 || cmd_cap[b_cmd] !== 26'd0) begin
            errors++; $display("FAIL load_then_clear[n=%0d]: got %0d cmds want 1 CLEAR", n, cmd_cap.size() - b_cmd);
        end
    endtask

    task automatic test_errors();
        cmd_ready = 1'b1;
        mark();
        send_str("TFX_C");        send_crlf();
        send_str("TFT_C:G,1234"); send_crlf();
        checks++;
        if (err_cnt - b_err !== 2 || cmd_cap.size() - b_cmd !== 0) begin
            errors++; $display("FAIL syntax_basic: got errs=%0d cmds=%0d want 2/0", err_cnt - b_err, cmd_cap.size() - b_cmd);
        end
        mark();
        send_str("TFT_C:1,123");   send_crlf();
        send_str("TFT_L");         send_crlf();
        send_str("TFT_C:1,12345"); send_crlf();
        send_str("TFT_Lx");        send_crlf();
        checks++;
        if (err_cnt - b_err !== 4 || cmd_cap.size() - b_cmd !== 0) begin
            errors++; $display("FAIL syntax_digits: got errs=%0d cmds=%0d want 4/0", err_cnt - b_err, cmd_cap.size() - b_cmd);
        end
        mark();
        send_str("TFT_C"); send_crlf();
        checks++;
        if (err_cnt - b_err !== 0 || cmd_cap.size() - b_cmd !== 1) begin
            errors++; $display("FAIL syntax_recover: got errs=%0d cmds=%0d want 0/1", err_cnt - b_err, cmd_cap.size() - b_cmd);
        end
    endtask

    task automatic test_overrun();
        cmd_ready = 1'b0;
        mark();
        send_str("TFT_C"); send_crlf();
        send_byte(8'h58, 1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        // Byte and ready in the same ISSUE cycle.
        send_str("TFT_C:3,00FF"); send_crlf();
        cmd_ready = 1'b1;
        send_byte(8'h59, 2);
        checks++;
        if (err_cnt - b_err !== 2) begin
            errors++; $display("FAIL overrun_err: got %0d want 2", err_cnt - b_err);
        end
        checks++;
        if (cmd_cap.size() - b_cmd !== 2 || cmd_cap[b_cmd] !== 26'd0 ||
            cmd_cap[b_cmd + 1] !== {2'd1, 4'h3, 20'h000FF}) begin
            errors++; $display("FAIL overrun_cmds: got %0d cmds want 2 (CLEAR, SETCOLOR 3/00FF)", cmd_cap.size() - b_cmd);
        end
    endtask

    task automatic test_timeout();
        cmd_ready = 1'b1;
        mark();
        send_load_hdr(20'h00007);
        for (int i = 0; i < 3; i++) send_pair(8'($urandom), $urandom_range(0, 3));
        repeat (TMO + 100) tick();
        checks++;
        if (px_cap.size() - b_px !== 3 || err_cnt - b_err !== 1 || done_cnt - b_done !== 0) begin
            errors++; $display("FAIL timeout: got px=%0d err=%0d done=%0d want 3/1/0",
                               px_cap.size() - b_px, err_cnt - b_err, done_cnt - b_done);
        end
        mark();
        send_str("TFT_C"); send_crlf();
        checks++;
        if (cmd_cap.size() - b_cmd !== 1 || cmd_cap[b_cmd] !== 26'd0) begin
            errors++; $display("FAIL timeout_recover: got %0d cmds want 1 CLEAR", cmd_cap.size() - b_cmd);
        end
    endtask

    task automatic test_reset_mid_stream();
        cmd_ready = 1'b1;
        send_load_hdr(20'h00007);
        send_pair(8'h5A, 1);
        send_pair(8'hC3, 0);
        sys_rst = 1'b1;
        #1;
        checks++;
        if ({cmd_valid, cmd_op, cmd_idx, cmd_data, px_data, px_valid, stream_done, err} !== 45'd0) begin
            errors++;
            $display("FAIL reset_mid_stream: got %h want 0",
                     {cmd_valid, cmd_op, cmd_idx, cmd_data, px_data, px_valid, stream_done, err});
        end
        repeat (2) tick();
        sys_rst = 1'b0;
        tick();
        mark();
        send_str("ABCD1234");
        repeat (5) tick();
        checks++;
        if (px_cap.size() - b_px !== 0 || err_cnt - b_err !== 0 || done_cnt - b_done !== 0) begin
            errors++; $display("FAIL reset_discard: got px=%0d err=%0d done=%0d want 0/0/0",
                               px_cap.size() - b_px, err_cnt - b_err, done_cnt - b_done);
        end
        mark();
        send_str("TFT_C"); send_crlf();
        checks++;
        if (cmd_cap.size() - b_cmd !== 1) begin
            errors++; $display("FAIL reset_recover: got %0d cmds want 1", cmd_cap.size() - b_cmd);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_setcolor();
        test_load(8, 1'b1);
        test_load(1, 1'b0);
        for (int i = 0; i < 3; i++) test_load($urandom_range(2, 24), 1'b0);
        test_errors();
        test_overrun();
        test_timeout();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
